// File: rtl/boot_pkg.sv
// ============================================================================
// boot_pkg -- shared types and constants for the UART instruction-memory loader
// Rev 1.0
// ============================================================================
`default_nettype none

package boot_pkg;

   localparam int         ADDR_W        = 31;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      WAIT_SYNC = 3'd0,
      LEN_HI    = 3'd1,
      LEN_LO    = 3'd2,
      DATA      = 3'd3,
      CSUM      = 3'd4,
      DONE      = 3'd5,
      ERROR     = 3'd6
   } state_e;

   function automatic logic [ADDR_W-1:0] word_addr(input logic [15:0] idx);
      return {{(ADDR_W-18){1'b0}}, idx, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_if.sv
// ============================================================================
// imem_loader_if -- byte stream in, instruction-memory write port and status out
// Rev 1.0
// ============================================================================
`default_nettype none

interface imem_loader_if;
   import boot_pkg::*;

   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              boot_skip;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;

   modport master (
      output rx_valid, rx_data, boot_skip,
      input  mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
   );

   modport slave (
      input  rx_valid, rx_data, boot_skip,
      output mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_err
   );

endinterface

`default_nettype wire

// File: rtl/idle_timer.sv
// ============================================================================
// idle_timer -- counts consecutive enabled cycles, flags the last allowed one
// Rev 1.0
// ============================================================================
`default_nettype none

module idle_timer #(
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] cnt_q;

   // expired is high during the TIMEOUT_CYC-th idle cycle so the caller leaves on that edge
   assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && !expired) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader -- receives a framed image over a byte stream and writes it to
// instruction memory, holding the CPU in reset until a valid frame lands.
// Rev 1.0
// ============================================================================
`default_nettype none

module imem_loader
   import boot_pkg::*;
#(
   parameter int         MEM_WORDS   = 150,
   parameter int         TIMEOUT_CYC = 100000,
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
   input  logic         clk,
   input  logic         reset,
   imem_loader_if.slave bus
);

   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [15:0]       idx_q, idx_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [23:0]       word_q, word_d;
   logic [7:0]        sum_q, sum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, done_q, err_q;

   logic              frame_active;
   logic              tmr_expired;
   logic [15:0]       len_rx;

   assign frame_active = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                         (state_q == DATA)   || (state_q == CSUM);
   assign len_rx       = {len_q[15:8], bus.rx_data};

   idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (bus.rx_valid || !frame_active),
      .enable  (frame_active && !bus.rx_valid),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;

      unique case (state_q)
         WAIT_SYNC: begin
            // a sync byte beats a simultaneous boot_skip
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
               state_d = LEN_HI;
            end else if (bus.boot_skip && !bus.rx_valid) begin
               state_d = DONE;
            end
         end
         LEN_HI: begin
            if (bus.rx_valid) begin
               len_d   = {bus.rx_data, 8'h00};
               state_d = LEN_LO;
            end
         end
         LEN_LO: begin
            if (bus.rx_valid) begin
               len_d = len_rx;
               if (len_rx == 16'd0 || len_rx > 16'(MEM_WORDS)) begin
                  state_d = ERROR;
               end else begin
                  state_d = DATA;
                  idx_d   = '0;
                  bcnt_d  = '0;
                  sum_d   = '0;
               end
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               sum_d  = sum_q + bus.rx_data;
               bcnt_d = bcnt_q + 2'd1;
               word_d = {word_q[15:0], bus.rx_data};
               if (bcnt_q == 2'd3) begin
                  we_d    = 1'b1;
                  addr_d  = word_addr(idx_q);
                  wdata_d = {word_q, bus.rx_data};
                  idx_d   = idx_q + 16'd1;
                  if (idx_q == len_q - 16'd1) begin
                     state_d = CSUM;
                  end
               end
            end
         end
         CSUM: begin
            if (bus.rx_valid) begin
               state_d = (8'(sum_q + bus.rx_data) == 8'd0) ? DONE : ERROR;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         ERROR: begin
            if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
               state_d = LEN_HI;
            end
         end
         default: begin
            state_d = WAIT_SYNC;
         end
      endcase

      if (tmr_expired) begin
         state_d = ERROR;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= WAIT_SYNC;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         sum_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         sum_q   <= sum_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         // status flags track the state being entered so they line up with it
         hold_q  <= (state_d != DONE);
         done_q  <= (state_d == DONE);
         err_q   <= (state_d == ERROR);
      end
   end

   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_hold  = hold_q;
   assign bus.load_done = done_q;
   assign bus.load_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader -- directed and randomized frames against a frame-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;
   import boot_pkg::*;

   localparam int MEM_WORDS = 150;
   localparam int TO        = 40;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   imem_loader_if bus ();

   imem_loader #(
      .MEM_WORDS   (MEM_WORDS),
      .TIMEOUT_CYC (TO),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [62:0] obs_wr[$];
   logic [62:0] exp_wr[$];
   logic [7:0]  fr[$];
   logic [31:0] words[$];

   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) obs_wr.push_back({bus.mem_addr, bus.mem_wdata});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic hold, input logic done, input logic err);
      chk({tag, " cpu_hold"},  64'(bus.cpu_hold),  64'(hold));
      chk({tag, " load_done"}, 64'(bus.load_done), 64'(done));
      chk({tag, " load_err"},  64'(bus.load_err),  64'(err));
   endtask

   task automatic cmp_writes(input string tag);
      tick(2);
      chk({tag, " wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         chk({tag, " wr"}, 64'(obs_wr[i]), 64'(exp_wr[i]));
      obs_wr.delete();
      exp_wr.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick(1);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic send_frame(input int maxgap);
      foreach (fr[i]) begin
         tick(int'($urandom_range(maxgap, 0)));
         send_byte(fr[i]);
      end
   endtask

   // Frame-level model: header, big-endian words, checksum making the byte sum zero (+delta)
   task automatic make_frame(input int n, input int delta, output bit ok);
      int sum;
      logic [7:0] b;
      fr.delete();
      fr.push_back(8'hA5);
      fr.push_back(8'((n >> 8) & 255));
      fr.push_back(8'(n & 255));
      ok = 1'b0;
      if (n >= 1 && n <= MEM_WORDS) begin
         sum = 0;
         for (int i = 0; i < n; i++) begin
            for (int k = 3; k >= 0; k--) begin
               b = 8'((words[i] >> (8 * k)) & 32'hFF);
               fr.push_back(b);
               sum += int'(b);
            end
            exp_wr.push_back({31'(i * 4), words[i]});
         end
         fr.push_back(8'((256 - (sum % 256) + delta) % 256));
         ok = ((delta % 256) == 0);
      end
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #2;
      chk_status({tag, " rst"}, 1'b1, 1'b0, 1'b0);
      chk({tag, " rst mem_we"},    64'(bus.mem_we),    64'd0);
      chk({tag, " rst mem_addr"},  64'(bus.mem_addr),  64'd0);
      chk({tag, " rst mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      obs_wr.delete();
      exp_wr.delete();
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      int delta;
      logic [7:0] junk;

      bus.rx_valid  = 1'b0;
      bus.rx_data   = 8'h00;
      bus.boot_skip = 1'b0;
      tick(1);
      do_reset("init");

      // Reference frame: two words, correct checksum
      words = '{32'h3C084000, 32'h8D090020};
      make_frame(2, 0, ok);
      send_frame(2);
      chk_status("good", !ok, ok, !ok);
      cmp_writes("good");

      // Checksum off by one, then resend the valid frame from ERROR
      do_reset("badcs");
      make_frame(2, 1, ok);
      send_frame(1);
      chk_status("badcs", !ok, ok, !ok);
      cmp_writes("badcs");
      make_frame(2, 0, ok);
      send_frame(1);
      chk_status("resend", !ok, ok, !ok);
      cmp_writes("resend");

      // Oversized length rejected after the low length byte
      do_reset("len151");
      make_frame(151, 0, ok);
      send_frame(1);
      chk_status("len151", 1'b1, 1'b0, 1'b1);
      cmp_writes("len151");

      // Inter-byte timeout mid-word
      do_reset("tmo");
      fr = '{8'hA5, 8'h00, 8'h01, 8'h3C, 8'h08};
      send_frame(2);
      tick(TO - 1);
      chk("tmo pre err", 64'(bus.load_err), 64'd0);
      tick(1);
      chk_status("tmo", 1'b1, 1'b0, 1'b1);
      cmp_writes("tmo");

      // boot_skip alone: straight to DONE, later bytes ignored
      do_reset("skip");
      bus.boot_skip = 1'b1;
      tick(1);
      bus.boot_skip = 1'b0;
      chk_status("skip", 1'b0, 1'b1, 1'b0);
      words = '{32'h11223344};
      make_frame(1, 0, ok);
      exp_wr.delete();
      send_frame(1);
      chk_status("skip ignore", 1'b0, 1'b1, 1'b0);
      cmp_writes("skip");

      // boot_skip with sync in the same cycle: the frame proceeds
      do_reset("skipsync");
      make_frame(1, 0, ok);
      void'(fr.pop_front());
      bus.boot_skip = 1'b1;
      send_byte(8'hA5);
      bus.boot_skip = 1'b0;
      chk_status("skipsync hdr", 1'b1, 1'b0, 1'b0);
      send_frame(1);
      chk_status("skipsync", !ok, ok, !ok);
      cmp_writes("skipsync");

      // Reset mid-frame after the second data byte; the tail must be ignored
      do_reset("midrst");
      words = '{32'h3C084000, 32'h8D090020};
      make_frame(2, 0, ok);
      exp_wr.delete();
      for (int i = 0; i < 5; i++) send_byte(fr.pop_front());
      do_reset("midrst");
      send_frame(1);
      chk_status("midrst", 1'b1, 1'b0, 1'b0);
      cmp_writes("midrst");

      // Randomized frames with junk prefix, random gaps, occasional bad length/checksum
      for (int it = 0; it < 10; it++) begin
         do_reset("rnd");
         for (int j = 0; j < int'($urandom_range(3, 0)); j++) begin
            junk = 8'($urandom);
            if (junk == 8'hA5) junk = 8'h5A;
            send_byte(junk);
         end
         n = int'($urandom_range(8, 1));
         if ($urandom_range(7, 0) == 0) n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(400, 151));
         words.delete();
         for (int j = 0; j < 8; j++) words.push_back($urandom);
         delta = ($urandom_range(2, 0) == 0) ? int'($urandom_range(255, 1)) : 0;
         make_frame(n, delta, ok);
         send_frame(3);
         chk_status("rnd", !ok, ok, !ok);
         cmp_writes("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 150: instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 100000: maximum idle cycles between bytes within a frame.
REQ-003 The block SHALL have parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 The block SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port rx_valid, input, 1: one-cycle pulse; rx_data is valid in that cycle.
REQ-007 The block SHALL have port rx_data, input, 8: received UART byte.
REQ-008 The block SHALL have port boot_skip, input, 1: run the existing image without loading.
REQ-009 The block SHALL have port mem_we, output, 1: instruction-memory write strobe.
REQ-010 The block SHALL have port mem_addr, output, 31: byte address, always word aligned (bits [1:0]=0).
REQ-011 The block SHALL have port mem_wdata, output, 32: instruction word.
REQ-012 The block SHALL have port cpu_hold, output, 1: while 1, the CPU is held in reset.
REQ-013 The block SHALL have port load_done, output, 1: image accepted and CPU released.
REQ-014 The block SHALL have port load_err, output, 1: frame rejected.

Function
REQ-015 The block SHALL always accept bytes; there is no backpressure, and a byte is consumed only in a cycle with rx_valid=1.
REQ-016 The block SHALL use states WAIT_SYNC, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
REQ-017 In WAIT_SYNC, a byte equal to SYNC_BYTE SHALL move the FSM to LEN_HI; other bytes SHALL be ignored; boot_skip=1 with no byte in the same cycle SHALL move the FSM to DONE.
REQ-018 In WAIT_SYNC, if boot_skip=1 and a SYNC_BYTE arrive in the same cycle, SYNC_BYTE SHALL win.
REQ-019 LEN_HI then LEN_LO SHALL capture a 16-bit word count N, MSB first; N=0 or N>MEM_WORDS SHALL go to ERROR after LEN_LO, otherwise the FSM SHALL go to DATA with word index and checksum cleared.
REQ-020 In DATA, bytes SHALL assemble big-endian (first byte -> bits [31:24]); the 8-bit checksum SHALL accumulate the modulo-256 sum of every data byte.
REQ-021 The cycle after the 4th byte of a word, mem_we SHALL pulse for exactly 1 cycle with mem_addr = index*4 and mem_wdata = the assembled word; the index SHALL then increment.
REQ-022 After word N-1 is written, the FSM SHALL go to CSUM; the next byte SHALL be accepted iff (sum + byte) mod 256 = 0, going to DONE, else to ERROR.
REQ-023 In DONE, cpu_hold SHALL be 0 and load_done SHALL be 1, all bytes SHALL be ignored, and the state SHALL hold until reset.
REQ-024 In ERROR, load_err SHALL be 1 and cpu_hold SHALL be 1; a SYNC_BYTE SHALL clear load_err and go to LEN_HI, and other bytes SHALL be ignored.
REQ-025 In LEN_HI, LEN_LO, DATA or CSUM, TIMEOUT_CYC consecutive cycles without rx_valid SHALL go to ERROR; the idle counter SHALL clear on every rx_valid.
REQ-026 Words already written before an ERROR SHALL remain in memory; a new frame SHALL overwrite from address 0.
REQ-027 cpu_hold, load_done and load_err SHALL be registered and derived only from state.
REQ-028 mem_we SHALL never assert outside the DATA-to-CSUM path, and never for index >= N.

Reset
REQ-029 Asserting reset SHALL immediately force WAIT_SYNC, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, load_done=0, load_err=0, and clear all counters and the checksum.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no further writes; after deassertion, the block SHALL wait for a new SYNC_BYTE.

Structure
REQ-031 Package boot_pkg SHALL hold the state enum, the SYNC_BYTE default and the width constant (31-bit address).
REQ-032 The inter-byte timeout counter SHALL be the sub-module idle_timer (inputs: clear, enable; output: expired).

Verification
REQ-033 The bench SHALL cover: bytes A5 00 02, then 3C 08 40 00, then 8D 09 00 20, then checksum 0x?? chosen so the sum is 0 -> mem_we at addr 0 = 32'h3C084000 and addr 4 = 32'h8D090020, then load_done=1 and cpu_hold=0.
REQ-034 The bench SHALL cover: the same frame with the checksum off by 1 -> load_err=1, cpu_hold=1, with both writes still observed; then a resend of the valid frame -> load_done=1.
REQ-035 The bench SHALL cover: A5 00 97 (N=151 > 150) -> ERROR after LEN_LO, with no mem_we.
REQ-036 The bench SHALL cover: A5 00 01 3C 08, then TIMEOUT_CYC idle cycles -> load_err=1 exactly at expiry, with no mem_we.
REQ-037 The bench SHALL cover: boot_skip=1 in WAIT_SYNC -> DONE next cycle (cpu_hold=0, no writes); boot_skip and A5 in the same cycle -> LEN_HI.
REQ-038 The bench SHALL cover: reset asserted after the 2nd data byte -> all outputs at reset values asynchronously, with no mem_we after release.
